// File: rtl/fb_scanout_if.sv
// Memory read handshake plus display byte stream of the framebuffer scanout.
// Master side is the scanout; slave side is the memory arbiter and display sink.
interface fb_scanout_if;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        out_valid;
    logic [7:0]  out_byte;
    logic        out_ready;

    modport master (
        output mem_read, mem_read_idx, out_valid, out_byte,
        input  mem_read_byte, mem_read_ack, out_ready
    );

    modport slave (
        input  mem_read, mem_read_idx, out_valid, out_byte,
        output mem_read_byte, mem_read_ack, out_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// Scans the 64x32 framebuffer into 1024 SSD1306 page bytes at 2x scale, four reads per 16 bytes.
// Latency: one read per ack plus one byte per accepted cycle; out_byte holds while out_ready is low.
module fb_scanout #(
    parameter logic [11:0] FB_BASE = 12'h100,
    parameter bit          INVERT  = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         frame_done,
    fb_scanout_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] EMIT = 2'd2;

    logic [1:0] state;
    logic [2:0] page;
    logic [2:0] bx;
    logic [1:0] row;
    logic [2:0] px;
    logic       dup;
    logic [7:0] rowbuf [4];
    logic [3:0] col;

    // One pixel column from the four buffered source rows; MSB is the leftmost pixel.
    always_comb begin
        col = '0;
        for (int i = 0; i < 4; i++) begin
            col[i] = rowbuf[i][3'd7 - px];
        end
    end

    assign busy              = (state != IDLE);
    assign bus.mem_read      = (state == LOAD) && !bus.mem_read_ack;
    assign bus.mem_read_idx  = bus.mem_read ? (FB_BASE + {4'd0, page, row, bx}) : 12'd0;
    assign bus.out_valid     = (state == EMIT);
    assign bus.out_byte      = (state == EMIT)
                             ? ({col[3], col[3], col[2], col[2], col[1], col[1], col[0], col[0]}
                                ^ {8{INVERT}})
                             : 8'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            page       <= '0;
            bx         <= '0;
            row        <= '0;
            px         <= '0;
            dup        <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rowbuf[i] <= '0;
            end
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        page  <= '0;
                        bx    <= '0;
                        row   <= '0;
                    end
                end
                LOAD: begin
                    if (bus.mem_read_ack) begin
                        rowbuf[row] <= bus.mem_read_byte;
                        if (row == 2'd3) begin
                            state <= EMIT;
                            px    <= '0;
                            dup   <= 1'b0;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        dup <= ~dup;
                        if (dup) begin
                            px <= px + 3'd1;
                        end
                        // Last doubled column of this framebuffer byte: fetch the next one.
                        if (dup && px == 3'd7) begin
                            bx  <= bx + 3'd1;
                            row <= '0;
                            if (bx == 3'd7) begin
                                page <= page + 3'd1;
                            end
                            if (bx == 3'd7 && page == 3'd7) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                state <= LOAD;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// Randomised scanout bench: pixel-level model of the 2x page stream and read order.
// A second instance with INVERT=1 runs against an all-zero, zero-wait memory.
module tb_fb_scanout;
    localparam int FB = 256;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic start_i = 1'b0;
    logic busy, frame_done, busy_i, fd_i;

    fb_scanout_if bus ();
    fb_scanout_if bus_i ();

    fb_scanout #(.FB_BASE(12'h100), .INVERT(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done), .bus(bus)
    );
    fb_scanout #(.FB_BASE(12'h100), .INVERT(1'b1)) dut_i (
        .clk(clk), .reset(reset), .start(start_i), .busy(busy_i), .frame_done(fd_i), .bus(bus_i)
    );

    always #5 clk = ~clk;

    logic [7:0]  fb [256];
    logic [7:0]  rcv [1024];
    logic [11:0] rd [256];
    int total = 0;
    int bad = 0;
    int nrcv, nreads, ndone, nrcv_i, ndone_i;
    int max_lat, wait_left;
    bit rand_ready, pend, fd_due, stall_prev;
    logic [11:0] pend_addr;
    logic [7:0]  stall_byte;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Pixel (x,y) of the 64x32 image; output byte k covers column k%128 of page k/128.
    function automatic logic pixel(input int x, input int y);
        logic [7:0] b;
        b = fb[y * 8 + x / 8];
        return b[7 - (x % 8)];
    endfunction

    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0] b;
        for (int j = 0; j < 8; j++) begin
            b[j] = pixel((k % 128) / 2, ((k / 128) * 8 + j) / 2);
        end
        return b;
    endfunction

    // Read n fetches source row (page*4 + n%4) of framebuffer byte column (n%32)/4.
    function automatic logic [11:0] exp_read(input int n);
        int y;
        int bxx;
        y   = (n / 32) * 4 + (n % 4);
        bxx = (n % 32) / 4;
        return 12'(FB + y * 8 + bxx);
    endfunction

    task automatic cycle();
        logic [11:0] off;
        bit rdy;
        @(negedge clk);
        bus.mem_read_ack   = 1'b0;
        bus_i.mem_read_ack = 1'b0;
        bus.mem_read_byte  = 8'($urandom);
        #1;
        chk("frame_done_timing", frame_done, fd_due);
        if (frame_done) begin
            ndone++;
            chk("busy_at_done", busy, 1'b0);
        end
        fd_due = 1'b0;

        if (pend) begin
            chk("read_held", bus.mem_read, 1'b1);
            chk("read_addr_held", bus.mem_read_idx, pend_addr);
            if (!bus.mem_read) pend = 1'b0;
        end else if (bus.mem_read) begin
            pend      = 1'b1;
            pend_addr = bus.mem_read_idx;
            wait_left = $urandom_range(max_lat, 0);
            chk("read_addr", pend_addr, exp_read(nreads));
            if (nreads < 256) rd[nreads] = pend_addr;
            nreads++;
        end
        if (pend) begin
            if (wait_left == 0) begin
                off = pend_addr - 12'(FB);
                bus.mem_read_ack  = 1'b1;
                bus.mem_read_byte = fb[off[7:0]];
                pend = 1'b0;
            end else begin
                wait_left--;
            end
        end

        if (stall_prev) begin
            chk("stall_valid", bus.out_valid, 1'b1);
            chk("stall_byte", bus.out_byte, stall_byte);
        end
        stall_prev = 1'b0;
        rdy = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
        bus.out_ready = rdy;
        if (bus.out_valid) begin
            if (nrcv < 1024) chk("out_byte", bus.out_byte, exp_byte(nrcv));
            else             chk("byte_overrun", nrcv, 1023);
            if (rdy) begin
                if (nrcv < 1024) rcv[nrcv] = bus.out_byte;
                nrcv++;
                if (nrcv == 1024) fd_due = 1'b1;
            end else begin
                stall_prev = 1'b1;
                stall_byte = bus.out_byte;
            end
        end

        if (bus_i.mem_read) bus_i.mem_read_ack = 1'b1;
        if (bus_i.out_valid) begin
            chk("inv_byte", bus_i.out_byte, 8'hFF);
            nrcv_i++;
        end
        if (fd_i) ndone_i++;
    endtask

    task automatic run_frame(input int lat, input bit rr, input bit mid_start);
        bit again;
        again      = 1'b0;
        nrcv       = 0;
        nreads     = 0;
        ndone      = 0;
        max_lat    = lat;
        rand_ready = rr;
        start = 1'b1;
        cycle();
        start   = 1'b0;
        start_i = 1'b0;
        for (int n = 0; n < 30000 && ndone == 0; n++) begin
            if (mid_start && !again && nrcv >= 500) begin
                again = 1'b1;
                chk("busy_mid_frame", busy, 1'b1);
                start = 1'b1;
                cycle();
                start = 1'b0;
            end else begin
                cycle();
            end
        end
        repeat (8) begin
            cycle();
            chk("idle_after_frame", busy, 1'b0);
        end
        chk("byte_count", nrcv, 1024);
        chk("read_count", nreads, 256);
        chk("done_count", ndone, 1);
    endtask

    initial begin
        bus.mem_read_ack    = 1'b0;
        bus.mem_read_byte   = 8'd0;
        bus.out_ready       = 1'b0;
        bus_i.mem_read_ack  = 1'b0;
        bus_i.mem_read_byte = 8'd0;
        bus_i.out_ready     = 1'b1;
        pend = 1'b0; fd_due = 1'b0; stall_prev = 1'b0;
        max_lat = 0; rand_ready = 1'b0;
        nrcv = 0; nreads = 0; ndone = 0; nrcv_i = 0; ndone_i = 0;
        for (int i = 0; i < 256; i++) fb[i] = 8'd0;

        repeat (3) cycle();
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_byte", bus.out_byte, 8'd0);
        chk("rst_mem_read", bus.mem_read, 1'b0);
        chk("rst_mem_idx", bus.mem_read_idx, 12'd0);
        reset = 1'b0;
        repeat (2) cycle();

        // Zeroed framebuffer, both polarities, zero-wait memory.
        start_i = 1'b1;
        run_frame(0, 1'b0, 1'b0);
        chk("zero_byte0", rcv[0], 8'h00);
        chk("zero_byte1023", rcv[1023], 8'h00);
        chk("inv_count", nrcv_i, 1024);
        chk("inv_done", ndone_i, 1);
        chk("inv_busy", busy_i, 1'b0);

        // Top-left pixel only.
        fb[0] = 8'h80;
        run_frame(0, 1'b0, 1'b0);
        chk("tl_byte0", rcv[0], 8'h03);
        chk("tl_byte1", rcv[1], 8'h03);
        chk("tl_byte2", rcv[2], 8'h00);
        chk("tl_byte128", rcv[128], 8'h00);

        // Bottom-right pixel only, with read address order pinned.
        fb[0]   = 8'h00;
        fb[255] = 8'h01;
        run_frame(1, 1'b1, 1'b0);
        chk("br_byte1021", rcv[1021], 8'h00);
        chk("br_byte1022", rcv[1022], 8'hC0);
        chk("br_byte1023", rcv[1023], 8'hC0);
        chk("rd0", rd[0], 12'h100);
        chk("rd1", rd[1], 12'h108);
        chk("rd2", rd[2], 12'h110);
        chk("rd3", rd[3], 12'h118);
        chk("rd255", rd[255], 12'h1FF);

        // Checkerboard under random ack latency and backpressure, start pulsed mid-frame.
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 8; b++)
                fb[r * 8 + b] = (r % 2 == 1) ? 8'h55 : 8'hAA;
        run_frame(5, 1'b1, 1'b1);
        chk("cb_byte0", rcv[0], 8'h33);
        chk("cb_byte1", rcv[1], 8'h33);
        chk("cb_byte2", rcv[2], 8'hCC);

        // Reset in the middle of a frame with a read outstanding.
        for (int i = 0; i < 256; i++) fb[i] = 8'($urandom);
        nrcv = 0; nreads = 0; ndone = 0;
        max_lat = 5; rand_ready = 1'b1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int n = 0; n < 20000 && !(nrcv >= 300 && pend); n++) cycle();
        chk("reset_point_pending", pend, 1'b1);
        reset = 1'b1;
        pend = 1'b0; fd_due = 1'b0; stall_prev = 1'b0;
        @(negedge clk);
        bus.mem_read_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_out_valid", bus.out_valid, 1'b0);
        chk("mid_rst_mem_read", bus.mem_read, 1'b0);
        chk("mid_rst_frame_done", frame_done, 1'b0);
        repeat (3) cycle();
        chk("mid_rst_no_done", ndone, 0);
        run_frame(3, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
